// File: rtl/csr_file.sv
// Machine-mode CSR file: decoded register set, 64-bit cycle/instret counters,
// trap entry/exit state, interrupt-pending detection and redirect-PC selection.
module csr_file #(
    parameter int              XLEN        = 32,
    parameter int unsigned     HART_ID     = 0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [31:0]     MISA_VALUE  = 32'h4000_0100
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            s_csr,
    input  logic            s_csrw,
    input  logic [2:0]      funct3,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] data_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            retire,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic [XLEN-1:0] data_out,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal,
    output logic            irq_pending
);

    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MCOUNTINH = 12'h320;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    // architectural state
    logic            st_mie, st_mpie;
    logic            ie_msie, ie_mtie, ie_meie;
    logic            inh_cy, inh_ir;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0]     cycle_q, instret_q;

    logic [XLEN-1:0] rdata, data_w, base_pc, vec_pc;
    logic            impl, wr_en;

    // pc_in low bits are always discarded; funct3[2] only picks imm vs rs1,
    // which is already folded into data_in; cause bit XLEN-2 shifts out of the vector offset
    logic unused_bits;
    assign unused_bits = ^{pc_in[1:0], funct3[2], trap_cause[XLEN-2]};

    // address decode and read mux; the high counter halves only exist at XLEN=32
    always_comb begin
        rdata = '0;
        impl  = 1'b1;
        case (addr)
            A_MVENDORID, A_MARCHID, A_MIMPID: rdata = '0;
            A_MHARTID:   rdata = XLEN'(HART_ID);
            A_MISA:      rdata = XLEN'(MISA_VALUE);
            A_MSTATUS:   rdata = XLEN'({19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0});
            A_MIE:       rdata = XLEN'({20'b0, ie_meie, 3'b0, ie_mtie, 3'b0, ie_msie, 3'b0});
            A_MIP:       rdata = XLEN'({20'b0, irq_ext, 3'b0, irq_timer, 7'b0});
            A_MTVEC:     rdata = mtvec_q;
            A_MSCRATCH:  rdata = mscratch_q;
            A_MEPC:      rdata = mepc_q;
            A_MCAUSE:    rdata = mcause_q;
            A_MTVAL:     rdata = mtval_q;
            A_MCOUNTINH: rdata = XLEN'({29'b0, inh_ir, 1'b0, inh_cy});
            A_MCYCLE, A_CYCLE:     rdata = XLEN'(cycle_q);
            A_MINSTRET, A_INSTRET: rdata = XLEN'(instret_q);
            A_MCYCLEH, A_CYCLEH: begin
                if (XLEN == 32) rdata = XLEN'(cycle_q[63:32]);
                else            impl  = 1'b0;
            end
            A_MINSTRETH, A_INSTRETH: begin
                if (XLEN == 32) rdata = XLEN'(instret_q[63:32]);
                else            impl  = 1'b0;
            end
            default: impl = 1'b0;
        endcase
    end

    // read-modify-write data for RW / RS / RC (immediate forms share the low bits)
    always_comb begin
        case (funct3[1:0])
            2'b01:   data_w = data_in;
            2'b10:   data_w = rdata | data_in;
            2'b11:   data_w = rdata & ~data_in;
            default: data_w = rdata;
        endcase
    end

    assign illegal     = s_csr & (~impl | (s_csrw & (addr[11:10] == 2'b11)));
    assign data_out    = s_csr ? rdata : '0;
    assign wr_en       = s_csr & s_csrw & ~illegal & ~trap;
    assign irq_pending = st_mie & ((ie_mtie & irq_timer) | (ie_meie & irq_ext));

    // redirect target: trap vector, mepc on MRET, otherwise the trap base
    assign base_pc = {mtvec_q[XLEN-1:2], 2'b00};
    assign vec_pc  = base_pc + {trap_cause[XLEN-3:0], 2'b00};
    always_comb begin
        pc_out = base_pc;
        if (trap) begin
            if (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1]) pc_out = vec_pc;
        end else if (mret) begin
            pc_out = mepc_q;
        end
    end

    // mstatus MIE/MPIE: trap beats mret, mret beats a CSR write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
        end else if (trap) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr_en && addr == A_MSTATUS) begin
            st_mie  <= data_w[3];
            st_mpie <= data_w[7];
        end
    end

    // trap capture registers; a trap discards any same-cycle CSR write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (trap) begin
            mepc_q   <= {pc_in[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
        end else if (wr_en) begin
            if (addr == A_MEPC)   mepc_q   <= {data_w[XLEN-1:2], 2'b00};
            if (addr == A_MCAUSE) mcause_q <= data_w;
            if (addr == A_MTVAL)  mtval_q  <= data_w;
        end
    end

    // plain writable CSRs; reserved mtvec modes keep the previous mode
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            ie_msie    <= 1'b0;
            ie_mtie    <= 1'b0;
            ie_meie    <= 1'b0;
            inh_cy     <= 1'b0;
            inh_ir     <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                A_MTVEC:     mtvec_q <= data_w[1] ? {data_w[XLEN-1:2], mtvec_q[1:0]} : data_w;
                A_MSCRATCH:  mscratch_q <= data_w;
                A_MIE: begin
                    ie_msie <= data_w[3];
                    ie_mtie <= data_w[7];
                    ie_meie <= data_w[11];
                end
                A_MCOUNTINH: begin
                    inh_cy <= data_w[0];
                    inh_ir <= data_w[2];
                end
                default: ;
            endcase
        end
    end

    // mcycle: a write to either half replaces this cycle's increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cycle_q <= '0;
        else if (wr_en && addr == A_MCYCLE)
            cycle_q <= (XLEN == 64) ? 64'(data_w) : {cycle_q[63:32], data_w[31:0]};
        else if (wr_en && addr == A_MCYCLEH)
            cycle_q <= {data_w[31:0], cycle_q[31:0]};
        else if (!inh_cy)
            cycle_q <= cycle_q + 64'd1;
    end

    // minstret: same write-override rule, counts retired instructions
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            instret_q <= '0;
        else if (wr_en && addr == A_MINSTRET)
            instret_q <= (XLEN == 64) ? 64'(data_w) : {instret_q[63:32], data_w[31:0]};
        else if (wr_en && addr == A_MINSTRETH)
            instret_q <= {data_w[31:0], instret_q[31:0]};
        else if (retire && !inh_ir)
            instret_q <= instret_q + 64'd1;
    end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file (XLEN=32, HART_ID=3): constant vector table, hand-written
// trap/irq/counter sequences, then random traffic against a reference model.
module tb_csr_file;

    typedef struct packed {
        logic        csr;
        logic        w;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] din;
        logic [31:0] pc;
        logic        retire;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] tval;
        logic        mret;
        logic        irq_t;
        logic        irq_e;
    } stim_t;

    typedef struct packed {
        logic        w;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] din;
        logic [31:0] exp_do;
        logic        exp_ill;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        s_csr, s_csrw, retire, trap, mret, irq_timer, irq_ext;
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [31:0] data_in, pc_in, trap_cause, trap_tval;
    logic [31:0] data_out, pc_out;
    logic        illegal, irq_pending;

    csr_file #(.XLEN(32), .HART_ID(3), .MTVEC_RESET(32'h0), .MISA_VALUE(32'h4000_0100)) dut (
        .clock(clock), .reset_n(reset_n), .s_csr(s_csr), .s_csrw(s_csrw), .funct3(funct3),
        .addr(addr), .data_in(data_in), .pc_in(pc_in), .retire(retire), .trap(trap),
        .trap_cause(trap_cause), .trap_tval(trap_tval), .mret(mret), .irq_timer(irq_timer),
        .irq_ext(irq_ext), .data_out(data_out), .pc_out(pc_out), .illegal(illegal),
        .irq_pending(irq_pending)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          mm_mie, mm_mpie;
    logic [31:0] mm_ie, mm_tvec, mm_scr, mm_epc, mm_cause, mm_tval, mm_inh;
    logic [63:0] mm_cyc, mm_ins;
    stim_t       cur;

    logic [11:0] addrs [0:25] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301,
                                  12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                  12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'h7C0, 12'h3A0,
                                  12'h000, 12'hB03};
    logic [2:0]  f3s [0:5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (addr %h): got %h expected %h", name, cur.addr, act, exp);
        end
    endtask

    function automatic void model_init();
        mm_mie = 0; mm_mpie = 0;
        mm_ie = 0; mm_tvec = 0; mm_scr = 0; mm_epc = 0;
        mm_cause = 0; mm_tval = 0; mm_inh = 0;
        mm_cyc = 0; mm_ins = 0;
    endfunction

    function automatic void model_read(input stim_t s, output logic [31:0] v, output bit impl);
        impl = 1;
        v    = 0;
        case (s.addr)
            12'hF11, 12'hF12, 12'hF13: v = 0;
            12'hF14: v = 3;
            12'h301: v = 32'h4000_0100;
            12'h300: v = 32'h1800 | (32'(mm_mpie) << 7) | (32'(mm_mie) << 3);
            12'h304: v = mm_ie;
            12'h305: v = mm_tvec;
            12'h340: v = mm_scr;
            12'h341: v = mm_epc;
            12'h342: v = mm_cause;
            12'h343: v = mm_tval;
            12'h344: v = (32'(s.irq_e) << 11) | (32'(s.irq_t) << 7);
            12'h320: v = mm_inh;
            12'hB00, 12'hC00: v = mm_cyc[31:0];
            12'hB80, 12'hC80: v = mm_cyc[63:32];
            12'hB02, 12'hC02: v = mm_ins[31:0];
            12'hB82, 12'hC82: v = mm_ins[63:32];
            default: impl = 0;
        endcase
    endfunction

    function automatic bit model_ill(input stim_t s);
        logic [31:0] v;
        bit          impl;
        model_read(s, v, impl);
        return s.csr && (!impl || (s.w && s.addr[11:10] == 2'b11));
    endfunction

    function automatic logic [31:0] model_pc(input stim_t s);
        logic [31:0] base;
        base = mm_tvec & 32'hFFFF_FFFC;
        if (s.trap)
            return (mm_tvec[1:0] == 2'b01 && s.cause[31]) ? base + ((s.cause & 32'h7FFF_FFFF) << 2) : base;
        if (s.mret) return mm_epc;
        return base;
    endfunction

    // state change at one clock edge, straight from the architectural rules
    function automatic void model_update();
        logic [31:0] rv, dw;
        bit          impl, we, old_mpie;
        logic [63:0] ncyc, nins;
        model_read(cur, rv, impl);
        we = cur.csr && cur.w && !model_ill(cur) && !cur.trap;
        case (cur.f3[1:0])
            2'b01:   dw = cur.din;
            2'b10:   dw = rv | cur.din;
            2'b11:   dw = rv & ~cur.din;
            default: dw = rv;
        endcase
        ncyc = mm_inh[0] ? mm_cyc : mm_cyc + 1;
        nins = (cur.retire && !mm_inh[2]) ? mm_ins + 1 : mm_ins;
        if (we) begin
            case (cur.addr)
                12'hB00: ncyc = {mm_cyc[63:32], dw};
                12'hB80: ncyc = {dw, mm_cyc[31:0]};
                12'hB02: nins = {mm_ins[63:32], dw};
                12'hB82: nins = {dw, mm_ins[31:0]};
                default: ;
            endcase
        end
        old_mpie = mm_mpie;
        if (cur.trap) begin
            mm_epc   = cur.pc & 32'hFFFF_FFFC;
            mm_cause = cur.cause;
            mm_tval  = cur.tval;
            mm_mpie  = mm_mie;
            mm_mie   = 0;
        end else begin
            if (we) begin
                case (cur.addr)
                    12'h300: begin mm_mie = dw[3]; mm_mpie = dw[7]; end
                    12'h304: mm_ie = dw & 32'h888;
                    12'h305: mm_tvec = dw[1] ? ((dw & 32'hFFFF_FFFC) | (mm_tvec & 32'h3)) : dw;
                    12'h340: mm_scr = dw;
                    12'h341: mm_epc = dw & 32'hFFFF_FFFC;
                    12'h342: mm_cause = dw;
                    12'h343: mm_tval = dw;
                    12'h320: mm_inh = dw & 32'h5;
                    default: ;
                endcase
            end
            if (cur.mret) begin
                mm_mie  = old_mpie;
                mm_mpie = 1;
            end
        end
        mm_cyc = ncyc;
        mm_ins = nins;
    endfunction

    task automatic apply(input stim_t s);
        cur        = s;
        s_csr      = s.csr;   s_csrw    = s.w;     funct3     = s.f3;
        addr       = s.addr;  data_in   = s.din;   pc_in      = s.pc;
        retire     = s.retire; trap     = s.trap;  trap_cause = s.cause;
        trap_tval  = s.tval;  mret      = s.mret;
        irq_timer  = s.irq_t; irq_ext   = s.irq_e;
    endtask

    // drive at the falling edge, compare all outputs against the model before the rising edge
    task automatic drive(input stim_t s);
        logic [31:0] rv;
        bit          impl;
        apply(s);
        #2;
        model_read(s, rv, impl);
        chk("data_out", data_out, s.csr ? rv : 32'h0);
        chk("illegal", 32'(illegal), 32'(model_ill(s)));
        chk("irq_pending", 32'(irq_pending),
            32'(mm_mie && ((s.irq_t && mm_ie[7]) || (s.irq_e && mm_ie[11]))));
        chk("pc_out", pc_out, model_pc(s));
    endtask

    task automatic edge_upd();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic step(input stim_t s);
        drive(s);
        edge_upd();
    endtask

    function automatic stim_t rd(input logic [11:0] a);
        stim_t s;
        s = '0; s.csr = 1; s.f3 = 3'd2; s.addr = a;
        return s;
    endfunction

    function automatic stim_t wr(input logic [2:0] f, input logic [11:0] a, input logic [31:0] d);
        stim_t s;
        s = '0; s.csr = 1; s.w = 1; s.f3 = f; s.addr = a; s.din = d;
        return s;
    endfunction

    function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [11:0] a,
                                input logic [31:0] d, input logic [31:0] e, input logic ill);
        vec_t v;
        v.w = w; v.f3 = f; v.addr = a; v.din = d; v.exp_do = e; v.exp_ill = ill;
        return v;
    endfunction

    vec_t  tbl [29];
    stim_t s;

    initial begin
        tbl[0]  = mk(0, 2, 12'hF14, 0, 32'h3, 0);
        tbl[1]  = mk(0, 2, 12'h301, 0, 32'h4000_0100, 0);
        tbl[2]  = mk(0, 2, 12'h7C0, 0, 32'h0, 1);
        tbl[3]  = mk(0, 2, 12'hF11, 0, 32'h0, 0);
        tbl[4]  = mk(0, 2, 12'h300, 0, 32'h1800, 0);
        tbl[5]  = mk(1, 1, 12'h340, 32'hA5A5_0000, 32'h0, 0);
        tbl[6]  = mk(1, 2, 12'h340, 32'h0F, 32'hA5A5_0000, 0);
        tbl[7]  = mk(1, 3, 12'h340, 32'h05, 32'hA5A5_000F, 0);
        tbl[8]  = mk(0, 2, 12'h340, 0, 32'hA5A5_000A, 0);
        tbl[9]  = mk(1, 1, 12'hF14, 32'h55, 32'h3, 1);
        tbl[10] = mk(1, 5, 12'h305, 32'h101, 32'h0, 0);
        tbl[11] = mk(1, 1, 12'h305, 32'h203, 32'h101, 0);
        tbl[12] = mk(0, 2, 12'h305, 0, 32'h201, 0);
        tbl[13] = mk(1, 1, 12'h341, 32'h207, 32'h0, 0);
        tbl[14] = mk(0, 2, 12'h341, 0, 32'h204, 0);
        tbl[15] = mk(1, 1, 12'h300, 32'hFFFF_FFFF, 32'h1800, 0);
        tbl[16] = mk(0, 2, 12'h300, 0, 32'h1888, 0);
        tbl[17] = mk(1, 1, 12'h304, 32'hFFFF_FFFF, 32'h0, 0);
        tbl[18] = mk(0, 2, 12'h304, 0, 32'h888, 0);
        tbl[19] = mk(1, 1, 12'h344, 32'hFFFF_FFFF, 32'h0, 0);
        tbl[20] = mk(0, 2, 12'h344, 0, 32'h0, 0);
        tbl[21] = mk(1, 6, 12'h320, 32'h7, 32'h0, 0);
        tbl[22] = mk(1, 7, 12'h320, 32'h7, 32'h5, 0);
        tbl[23] = mk(0, 2, 12'h320, 0, 32'h0, 0);
        tbl[24] = mk(1, 1, 12'h305, 32'h101, 32'h201, 0);
        tbl[25] = mk(0, 2, 12'h305, 0, 32'h101, 0);
        tbl[26] = mk(1, 1, 12'h301, 32'h0, 32'h4000_0100, 0);
        tbl[27] = mk(0, 2, 12'h301, 0, 32'h4000_0100, 0);
        tbl[28] = mk(0, 2, 12'h3A0, 0, 32'h0, 1);

        // reset state
        reset_n = 1'b0;
        apply('0);
        #2;
        chk("rst.data_out", data_out, 32'h0);
        chk("rst.illegal", 32'(illegal), 32'h0);
        chk("rst.irq_pending", 32'(irq_pending), 32'h0);
        chk("rst.pc_out", pc_out, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        model_init();

        // constant vector table
        for (int i = 0; i < 29; i++) begin
            s = '0;
            s.csr = 1; s.w = tbl[i].w; s.f3 = tbl[i].f3; s.addr = tbl[i].addr; s.din = tbl[i].din;
            drive(s);
            chk($sformatf("tbl%0d.data_out", i), data_out, tbl[i].exp_do);
            chk($sformatf("tbl%0d.illegal", i), 32'(illegal), 32'(tbl[i].exp_ill));
            edge_upd();
        end

        // vectored interrupt trap (MIE=1, MPIE=1 beforehand)
        s = '0; s.trap = 1; s.cause = 32'h8000_0007; s.tval = 32'hDEAD; s.pc = 32'h204;
        drive(s); chk("trap.vec_pc", pc_out, 32'h11C); edge_upd();
        drive(rd(12'h341)); chk("trap.mepc", data_out, 32'h204); edge_upd();
        drive(rd(12'h300)); chk("trap.mstatus", data_out, 32'h1880); edge_upd();
        drive(rd(12'h342)); chk("trap.mcause", data_out, 32'h8000_0007); edge_upd();
        s = '0; s.trap = 1; s.cause = 32'h2; s.pc = 32'h400;
        drive(s); chk("exc.pc", pc_out, 32'h100); edge_upd();
        drive('0); chk("idle.pc", pc_out, 32'h100); edge_upd();

        // interrupt pending, trap, mret
        step(wr(1, 12'h300, 32'h8));
        s = '0; s.irq_t = 1;
        drive(s); chk("irq.pending", 32'(irq_pending), 32'h1); edge_upd();
        s = '0; s.irq_t = 1; s.trap = 1; s.cause = 32'h8000_0007; s.pc = 32'h300;
        drive(s); chk("irq.trap_pc", pc_out, 32'h11C); edge_upd();
        s = '0; s.irq_t = 1;
        drive(s); chk("irq.masked", 32'(irq_pending), 32'h0); edge_upd();
        s = '0; s.irq_t = 1; s.mret = 1;
        drive(s); chk("mret.pc", pc_out, 32'h300); edge_upd();
        s = rd(12'h300); s.irq_t = 1;
        drive(s); chk("mret.mstatus", data_out, 32'h1888);
        chk("mret.pending", 32'(irq_pending), 32'h1); edge_upd();
        s = wr(1, 12'h300, 32'h0); s.mret = 1;
        step(s);
        drive(rd(12'h300)); chk("mret_vs_write", data_out, 32'h1888); edge_upd();
        s = '0; s.trap = 1; s.mret = 1; s.cause = 32'h3; s.pc = 32'h500;
        drive(s); chk("trap_vs_mret.pc", pc_out, 32'h100); edge_upd();
        drive(rd(12'h341)); chk("trap_vs_mret.mepc", data_out, 32'h500); edge_upd();

        // counter write, carry into the high half, inhibit
        step(wr(1, 12'hB80, 32'h0));
        step(wr(1, 12'hB00, 32'hFFFF_FFFE));
        step('0); step('0); step('0);
        drive(rd(12'hB00)); chk("cyc.lo", data_out, 32'h1); edge_upd();
        drive(rd(12'hB80)); chk("cyc.hi", data_out, 32'h1); edge_upd();
        step(wr(6, 12'h320, 32'h1));
        drive(rd(12'hB00)); chk("cyc.inh1", data_out, 32'h4); edge_upd();
        step('0);
        drive(rd(12'hB00)); chk("cyc.inh2", data_out, 32'h4); edge_upd();
        drive(rd(12'hC80)); chk("cyc.user_hi", data_out, 32'h1); edge_upd();
        step(wr(7, 12'h320, 32'h1));

        // retire + trap + mstatus write in one cycle; read-only counter writes
        step(wr(1, 12'h300, 32'h8));
        s = wr(1, 12'h300, 32'h8); s.retire = 1; s.trap = 1; s.cause = 32'h5; s.pc = 32'h600;
        step(s);
        drive(rd(12'h300)); chk("combo.mstatus", data_out, 32'h1880); edge_upd();
        drive(rd(12'h342)); chk("combo.mcause", data_out, 32'h5); edge_upd();
        drive(rd(12'hB02)); chk("combo.minstret", data_out, 32'h1); edge_upd();
        drive(wr(1, 12'hC00, 32'h0)); chk("ro.cycle_ill", 32'(illegal), 32'h1); edge_upd();
        step(rd(12'hC00));
        drive(wr(2, 12'hC02, 32'h0)); chk("ro.instret_ill", 32'(illegal), 32'h1); edge_upd();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.csr    = ($urandom_range(0, 3) != 0);
            s.w      = 1'($urandom_range(0, 1));
            s.f3     = f3s[$urandom_range(0, 5)];
            s.addr   = addrs[$urandom_range(0, 25)];
            s.din    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            s.pc     = $urandom();
            s.retire = 1'($urandom_range(0, 1));
            s.trap   = ($urandom_range(0, 11) == 0);
            s.cause  = $urandom() & 32'h8000_001F;
            s.tval   = $urandom();
            s.mret   = ($urandom_range(0, 9) == 0);
            s.irq_t  = 1'($urandom_range(0, 1));
            s.irq_e  = 1'($urandom_range(0, 1));
            step(s);
        end

        // asynchronous reset mid-run
        reset_n = 1'b0;
        apply(rd(12'h340));
        #2;
        chk("arst.mscratch", data_out, 32'h0);
        chk("arst.illegal", 32'(illegal), 32'h0);
        apply(rd(12'h300));
        #1;
        chk("arst.mstatus", data_out, 32'h1800);
        apply('0);
        #1;
        chk("arst.data_out", data_out, 32'h0);
        chk("arst.pc_out", pc_out, 32'h0);
        chk("arst.irq", 32'(irq_pending), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        model_init();
        step(rd(12'h340));
        step(rd(12'hB00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR file that succeeds the flat 4096-entry CSR array with a decoded, parametrised register set. It sits beside the execute stage and serves CSRRW/S/C(I) reads and writes. It also provides 64-bit cycle and instret counters, trap entry/exit state (mepc/mcause/mtval/mstatus), and interrupt-pending detection. It drives the redirect PC for traps and MRET.

Parameters:
XLEN, 32, data width; 32 or 64. High-half counter CSRs exist only when XLEN=32.
HART_ID, 0, value read from mhartid.
MTVEC_RESET, 0, reset value of mtvec; bits[1:0] select the mode.
MISA_VALUE, 32'h40000100, value read from misa (RV32I); zero-extended when XLEN=64.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
s_csr  in  1  CSR instruction valid this cycle
s_csrw  in  1  CSR write enable; ignored unless s_csr=1
funct3  in  3  CSRRW/CSRRS/CSRRC and immediate forms, per defines.vh
addr  in  12  CSR address
data_in  in  XLEN  rs1 value or zero-extended immediate
pc_in  in  XLEN  PC of the current instruction
retire  in  1  one instruction retired this cycle
trap  in  1  take trap this cycle
trap_cause  in  XLEN  mcause value; MSB set means interrupt
trap_tval  in  XLEN  mtval value
mret  in  1  MRET executes this cycle
irq_timer  in  1  machine timer interrupt level
irq_ext  in  1  machine external interrupt level
data_out  out  XLEN  CSR read data, combinational
pc_out  out  XLEN  redirect target, combinational
illegal  out  1  illegal CSR access, combinational
irq_pending  out  1  enabled interrupt pending, combinational

Behaviour:
- Reset: async on reset_n low. All CSRs clear to 0 except mtvec=MTVEC_RESET and mstatus.MPP=2'b11 (hardwired).
- Reset: all outputs are combinational, so with state cleared and s_csr=0, data_out=0, illegal=0 and irq_pending=0.
- Implemented CSRs: mvendorid, marchid, mimpid (read as 0); mhartid; misa; mstatus; mie; mtvec; mscratch; mepc; mcause; mtval; mip; mcountinhibit; mcycle; minstret; cycle; instret.
- XLEN=32 also implements mcycleh, minstreth, cycleh and instreth.
- Write data: data_w = data_in (RW), data_out|data_in (RS), data_out&~data_in (RC). data_w commits at the next clock edge.
- Read: data_out shows the pre-write value in the same cycle. Unimplemented addresses read 0.
- illegal=1 when s_csr=1 and either condition holds; no state changes:
  - the address is unimplemented;
  - s_csrw=1 and addr[11:10]==2'b11 (read-only space).
- mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11. All other bits read 0.
- mie: only MSIE[3], MTIE[7] and MEIE[11] are writable.
- mip: MTIP[7]=irq_timer and MEIP[11]=irq_ext; read-only, writes ignored.
- mtvec: base is bits[XLEN-1:2]. Mode in bits[1:0]: 0 = direct, 1 = vectored. A write with mode 2 or 3 updates the base and keeps the old mode.
- mepc: bits[1:0] are forced to 0 on every write.
- mcountinhibit: only bit0 (CY) and bit2 (IR) are writable.
- Counters are 64-bit and wrap from all-ones to 0.
  - mcycle increments every cycle unless CY=1.
  - minstret increments when retire=1 unless IR=1.
  - A CSR write to any half of a counter overrides that cycle's increment for the whole counter. The written half takes data_w; the other half holds its current value.
  - With XLEN=64, mcycle and minstret read and write the full 64 bits.
- Trap (trap=1), at the clock edge:
  - mepc<=pc_in with bits[1:0] cleared, mcause<=trap_cause, mtval<=trap_tval;
  - MPIE<=MIE, MIE<=0.
- Trap pc_out:
  - direct mode: {base,2'b00};
  - vectored mode with interrupt: base + 4*trap_cause[XLEN-2:0];
  - vectored mode with exception: {base,2'b00}.
- MRET (mret=1 and trap=0): MIE<=MPIE, MPIE<=1, pc_out=mepc.
- pc_out when neither trap nor mret is active: {base,2'b00}.
- Simultaneous events:
  - trap together with mret: the trap wins and mret is ignored;
  - trap together with a CSR write: the trap wins and the write is discarded;
  - mret together with a CSR write to mstatus: the mret update wins.
- irq_pending = MIE & |(mip & mie). The core converts it into a trap; this block never self-traps.

Test Plan:
- Reset, then read mhartid with HART_ID=3 -> data_out=3. Read misa -> 32'h40000100. Read addr 12'h7C0 -> data_out=0, illegal=1.
- CSRRW mscratch 32'hA5A5_0000; CSRRS data_in=32'h0F; CSRRC data_in=32'h05 -> reads return the old value each time. Final mscratch=32'hA5A5_000A.
- Write mtvec 32'h100|1, then trap with cause 32'h8000_0007 at pc_in=32'h204 -> pc_out=32'h11C. Next cycle: mepc=32'h204, MIE=0, MPIE=the old MIE.
- Set MIE=1, MTIE=1, raise irq_timer -> irq_pending=1. Trap, then mret -> pc_out=mepc, MIE=1, MPIE=1.
- XLEN=32: write mcycle 32'hFFFF_FFFE with mcycleh=0 -> after 3 cycles, mcycleh=1 and mcycle=1. Set CY=1 -> mcycle holds.
- Retire, trap and a write to mstatus in the same cycle -> the trap state wins and minstret increments. A CSRRW to cycle (12'hC00) -> illegal=1 and the counter is not written.
